// File: rtl/seconds_ones_counter.sv
// rtl/seconds_ones_counter.sv - seconds-ones BCD digit with 1 Hz prescaler, run/stop, clear and preset load
// Optional 7-segment output (active-low, registered) enabled by defining SECONDS_ONES_SEG7_EN.
module seconds_ones_counter #(
  parameter int CLK_FREQ = 50000000,
  parameter int TICK_HZ  = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] bcd,
  output logic       tick,
  output logic       carry,
  output logic       running
`ifdef SECONDS_ONES_SEG7_EN
  ,
  output logic [6:0] seg
`endif
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("seconds_ones_counter: CLK_FREQ/TICK_HZ must be at least 2");
  end

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_next;
  logic [3:0]    bcd_next;
  logic          tick_next;
  logic          carry_next;
  logic          wrap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= STOPPED;
    end else begin
      state <= state_next;
    end
  end

  // Priority is clear > load > count; start_stop toggles independently so
  // a wrap on the toggle edge still completes before the state changes.
  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    bcd_next       = bcd;
    tick_next      = 1'b0;
    carry_next     = 1'b0;
    wrap           = (state == RUNNING) && (prescaler == PRESC_MAX);

    if (start_stop) begin
      state_next = (state == STOPPED) ? RUNNING : STOPPED;
    end

    if (clear) begin
      prescaler_next = '0;
      bcd_next       = 4'd0;
    end else if (load && (state == STOPPED)) begin
      if (load_value <= 4'd9) begin
        bcd_next       = load_value;
        prescaler_next = '0;
      end
    end else if (state == RUNNING) begin
      if (wrap) begin
        prescaler_next = '0;
        tick_next      = 1'b1;
        carry_next     = (bcd >= 4'd9);
        bcd_next       = (bcd >= 4'd9) ? 4'd0 : bcd + 4'd1;
      end else begin
        prescaler_next = prescaler + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      bcd       <= 4'd0;
      tick      <= 1'b0;
      carry     <= 1'b0;
      running   <= 1'b0;
    end else begin
      prescaler <= prescaler_next;
      bcd       <= bcd_next;
      tick      <= tick_next;
      carry     <= carry_next;
      running   <= (state_next == RUNNING);
    end
  end

`ifdef SECONDS_ONES_SEG7_EN
  logic [6:0] seg_next;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  always_comb begin
    seg_next = 7'b1111111;
    case (bcd)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b1111111;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg <= 7'b1000000;
    end else begin
      seg <= seg_next;
    end
  end
`endif

endmodule

// File: tb/tb_seconds_ones_counter.sv
// tb/tb_seconds_ones_counter.sv - scoreboard bench for seconds_ones_counter with DIV=10
module tb_seconds_ones_counter;

  localparam int DIV = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] bcd;
  logic       tick;
  logic       carry;
  logic       running;
`ifdef SECONDS_ONES_SEG7_EN
  logic [6:0] seg;
`endif

  seconds_ones_counter #(
    .CLK_FREQ(10),
    .TICK_HZ (1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start_stop(start_stop),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .bcd       (bcd),
    .tick      (tick),
    .carry     (carry),
    .running   (running)
`ifdef SECONDS_ONES_SEG7_EN
    ,
    .seg       (seg)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] bcd;
    logic       tick;
    logic       carry;
    logic       running;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  bit   m_run = 1'b0;
  int   m_presc = 0;
  int   m_bcd = 0;
  bit   m_tick;
  bit   m_carry;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("sb_bcd", int'(bcd), int'(mon_e.bcd));
      check("sb_tick", int'(tick), int'(mon_e.tick));
      check("sb_carry", int'(carry), int'(mon_e.carry));
      check("sb_running", int'(running), int'(mon_e.running));
    end
  end

  task automatic step(input bit ss, input bit cl, input bit ld, input int lv);
    bit wrap;
    start_stop = ss;
    clear      = cl;
    load       = ld;
    load_value = 4'(lv);
    wrap       = m_run && (m_presc == DIV - 1);
    m_tick     = 1'b0;
    m_carry    = 1'b0;
    if (cl) begin
      m_presc = 0;
      m_bcd   = 0;
    end else if (ld && !m_run) begin
      if (lv <= 9) begin
        m_bcd   = lv;
        m_presc = 0;
      end
    end else if (m_run) begin
      if (wrap) begin
        m_presc = 0;
        m_tick  = 1'b1;
        m_carry = (m_bcd == 9);
        m_bcd   = (m_bcd == 9) ? 0 : m_bcd + 1;
      end else begin
        m_presc++;
      end
    end
    if (ss) m_run = !m_run;
    sb_q.push_back('{bcd: 4'(m_bcd), tick: m_tick, carry: m_carry, running: m_run});
    @(posedge clock);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic run_until_tick(input string tag, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      step(1'b0, 1'b0, 1'b0, 0);
      n++;
      if (tick) break;
    end
    if (!tick) check({tag, "_timeout"}, n, -1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int ticks;
    int carries;
    int last_tick;
    int held;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_bcd", int'(bcd), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_running", int'(running), 0);
`ifdef SECONDS_ONES_SEG7_EN
    check("rst_seg", int'(seg), int'(7'b1000000));
`endif
    reset_n = 1'b1;

    step(1'b1, 1'b0, 1'b0, 0);
    check("start_running", int'(running), 1);
    run_until_tick("first_tick", 20, n);
    check("first_tick_latency", n, 10);
    check("first_tick_bcd", int'(bcd), 1);
    check("first_tick_carry", int'(carry), 0);

    ticks = 0;
    carries = 0;
    last_tick = 0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b0, 1'b0, 1'b0, 0);
      if (tick) begin
        ticks++;
        check("tick_period", i - last_tick, DIV);
        last_tick = i;
      end
      if (carry) begin
        carries++;
        check("carry_with_zero", int'(bcd), 0);
      end
    end
    check("ticks_in_100", ticks, 10);
    check("carries_in_100", carries, 1);
    check("bcd_after_100", int'(bcd), 1);

    idle(3);
    step(1'b1, 1'b0, 1'b0, 0);
    check("stop_running", int'(running), 0);
    held = int'(bcd);
    idle(20);
    check("stop_bcd_hold", int'(bcd), held);
    step(1'b1, 1'b0, 1'b0, 0);
    run_until_tick("resume", 20, n);
    check("resume_latency", n, 6);

    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 7);
    check("load_7", int'(bcd), 7);
    step(1'b0, 1'b0, 1'b1, 12);
    check("load_12_ignored", int'(bcd), 7);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 3);
    check("load_running_ignored", int'(bcd), 7);
    for (int k = 1; k <= 3; k++) begin
      run_until_tick("preset_run", 20, n);
      check("preset_carry", int'(carry), (k == 3) ? 1 : 0);
    end

    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 9);
`ifdef SECONDS_ONES_SEG7_EN
    step(1'b0, 1'b0, 1'b0, 0);
    check("seg_nine", int'(seg), int'(7'b0010000));
`endif
    step(1'b1, 1'b0, 1'b0, 0);
    idle(9);
    step(1'b0, 1'b1, 1'b0, 0);
    check("clear_wrap_bcd", int'(bcd), 0);
    check("clear_wrap_tick", int'(tick), 0);
    check("clear_wrap_carry", int'(carry), 0);
    check("clear_wrap_running", int'(running), 1);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 14) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
    end

    if (!running) step(1'b1, 1'b0, 1'b0, 0);
    idle(4);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_bcd", int'(bcd), 0);
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_carry", int'(carry), 0);
    check("async_rst_running", int'(running), 0);
`ifdef SECONDS_ONES_SEG7_EN
    check("async_rst_seg", int'(seg), int'(7'b1000000));
`endif
    @(negedge clock);
    reset_n = 1'b1;
    m_run   = 1'b0;
    m_presc = 0;
    m_bcd   = 0;
    step(1'b1, 1'b0, 1'b0, 0);
    run_until_tick("post_reset", 20, n);
    check("post_reset_latency", n, 10);
    check("post_reset_bcd", int'(bcd), 1);

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seconds_ones_counter.md
Name: seconds_ones_counter

Overview:
Upstream neighbour of the seconds-tens counter. Divides the board clock down to a 1 Hz tick and counts the seconds-ones BCD digit 0..9. Drives its bcd output into the tens stage's bcd_1s input, which clocks on the 9->0 rollover. Also provides a registered single-cycle carry pulse for synchronous downstream stages, plus run/stop control and preset load.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
TICK_HZ, 1, count rate in Hz; DIV = CLK_FREQ/TICK_HZ, DIV >= 2 required (elaboration error otherwise)

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start_stop  input  1  single-cycle pulse (already debounced); toggles STOPPED/RUNNING
clear  input  1  synchronous clear of digit and prescaler
load  input  1  synchronous preset strobe, honoured only in STOPPED
load_value  input  4  preset digit
bcd  output  4  seconds-ones digit, 0..9
tick  output  1  registered 1-cycle pulse per prescaler wrap
carry  output  1  registered 1-cycle pulse when digit wraps 9->0
running  output  1  high in RUNNING

Behaviour:
- One clock: clock. Reset is asynchronous and active-low: reset_n.
- Reset (reset_n=0, asynchronous): state=STOPPED, prescaler=0, bcd=0, tick=0, carry=0, running=0. Released synchronously to the next rising edge; no tick in the first DIV-1 running cycles after release.
- FSM, two states:
  - STOPPED: prescaler and bcd hold.
  - RUNNING: prescaler increments every cycle.
  - start_stop=1 toggles the state on that edge. running is a registered copy of the state.
- Prescaler: width $clog2(DIV), counts 0..DIV-1. On the edge where prescaler==DIV-1 in RUNNING:
  - prescaler goes to 0.
  - bcd goes to bcd+1, or to 0 if bcd>=9.
  - tick goes to 1 for exactly the next cycle.
  - carry goes to 1 for exactly the next cycle, only if bcd was 9.
- tick and carry are 0 in every other cycle. bcd and carry change on the same edge, so carry is high while bcd==0.
- Period: first tick DIV edges after entering RUNNING with prescaler=0; then exactly one every DIV cycles.
- Stop mid-period: prescaler keeps its partial count. Resume continues from it, so no time is lost or gained.
- start_stop on the same edge as the prescaler wrap: the wrap takes effect (tick and increment occur), then the state toggles.
- clear=1, in either state:
  - prescaler=0, bcd=0, tick=0, carry=0 on that edge.
  - Overrides a wrap on the same edge: no tick, no carry.
  - Does not change the state. A start_stop on the same edge still toggles.
- load=1 in STOPPED and clear=0:
  - load_value<=9: bcd=load_value, prescaler=0.
  - load_value>9: ignored, everything holds.
- load in RUNNING is ignored. load never produces tick or carry.
- Priority on one edge: reset_n > clear > load > count.
- bcd is never outside 0..9 after reset.

Optional Feature:
SECONDS_ONES_SEG7_EN:
- Defined: adds output seg [6:0], active-low 7-segment pattern of bcd (bit0=a .. bit6=g), registered. It updates one cycle after bcd changes and reads 7'b1000000 ("0") on reset.
- Undefined: no seg port and no decoder logic. The other ports are unchanged.

Test Plan:
All scenarios use CLK_FREQ=10, TICK_HZ=1 (DIV=10).
- Reset then one start_stop pulse: running=1 next cycle; first tick 10 cycles after the pulse edge; bcd 0->1 with tick; carry=0.
- Run 100 cycles from 0: bcd goes 1..9 then 0; exactly one carry pulse, coincident with bcd==0; tick period exactly 10 cycles.
- Stop after 4 prescaler counts, wait 20 cycles, restart: bcd holds during the stop; next tick arrives exactly 6 cycles after restart.
- STOPPED: load with load_value=7 -> bcd=7. Then load_value=12 -> bcd stays 7. Load while RUNNING -> ignored. Run from 7: carry occurs on the 3rd tick.
- clear asserted on a wrap edge with bcd=9: bcd=0, no tick, no carry, running unchanged.
- reset_n pulsed low mid-period between edges: all outputs 0 immediately, without waiting for a clock edge. With SECONDS_ONES_SEG7_EN defined, also check seg=7'b1000000 at reset and seg=7'b0010000 for bcd=9.
